// File: rtl/adc_capture_buf_if.sv
// adc_capture_buf_if: control, sample and dual read-port signals of the
// ADC capture buffer.
//   master : capture controller / reader (drives start, stop, mode,
//            sample_valid, data_i, rd_en_*, rd_addr_*)
//   slave  : the capture buffer (drives rd_data_*, rd_valid_*, busy, done, count)
interface adc_capture_buf_if #(
    parameter int ND = 14,
    parameter int NA = 8
);
    logic          start;
    logic          stop;
    logic          mode;
    logic          sample_valid;
    logic [ND-1:0] data_i;
    logic          rd_en_a;
    logic          rd_en_b;
    logic [NA-1:0] rd_addr_a;
    logic [NA-1:0] rd_addr_b;
    logic [ND-1:0] rd_data_a;
    logic [ND-1:0] rd_data_b;
    logic          rd_valid_a;
    logic          rd_valid_b;
    logic          busy;
    logic          done;
    logic [NA:0]   count;

    modport master (
        output start, stop, mode, sample_valid, data_i,
        output rd_en_a, rd_en_b, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b,
        input  busy, done, count
    );

    modport slave (
        input  start, stop, mode, sample_valid, data_i,
        input  rd_en_a, rd_en_b, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b,
        output busy, done, count
    );
endinterface

// File: rtl/adc_capture_buf.sv
// adc_capture_buf: ADC sample capture buffer of 2^NA samples with single-shot
// and continuous (ring) modes and two independent 1-cycle-latency read ports.
// Reads use logical addresses (0 = oldest sample) once the capture is DONE.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   bus   : adc_capture_buf_if slave modport (start/stop/mode, sample input,
//           read ports A and B, busy/done/count status)
module adc_capture_buf #(
    parameter int ND = 14,
    parameter int NA = 8
) (
    input logic              clk,
    input logic              rst_n,
    adc_capture_buf_if.slave bus
);
    localparam int          DEPTH = 1 << NA;
    localparam logic [NA:0] FULL  = {1'b1, {NA{1'b0}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t        state_q, state_d;
    logic [NA-1:0] wr_ptr_q, wr_ptr_d;
    logic [NA:0]   count_q, count_d;
    logic          mode_q, mode_d;
    logic [NA-1:0] base_q, base_d;
    logic          we;

    logic [ND-1:0] mem [DEPTH];
    logic [NA-1:0] rd_base, phys_a, phys_b;
    logic [ND-1:0] rd_data_a_q, rd_data_b_q;
    logic          rd_valid_a_q, rd_valid_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mode_d   = mode_q;
        base_d   = base_q;
        we       = 1'b0;
        if (bus.start) begin
            // start wins over stop and restarts even mid-capture
            state_d  = CAPTURE;
            wr_ptr_d = '0;
            count_d  = '0;
            mode_d   = bus.mode;
            base_d   = '0;
        end else if (state_q == CAPTURE) begin
            if (bus.sample_valid) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != FULL) count_d = count_q + 1'b1;
            end
            // the closing write (if any) is included before base is taken:
            // a full ring has its oldest sample at the next write slot
            if ((!mode_q && count_d == FULL) || (mode_q && bus.stop)) begin
                state_d = DONE;
                base_d  = (count_d == FULL) ? wr_ptr_d : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= bus.data_i;
    end

    // logical -> physical mapping only applies once the capture has ended
    assign rd_base = (state_q == DONE) ? base_q : '0;
    assign phys_a  = bus.rd_addr_a + rd_base;
    assign phys_b  = bus.rd_addr_b + rd_base;

    // nonblocking read of mem gives pre-write data on a same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            rd_valid_a_q <= bus.rd_en_a;
            rd_valid_b_q <= bus.rd_en_b;
            if (bus.rd_en_a) rd_data_a_q <= mem[phys_a];
            if (bus.rd_en_b) rd_data_b_q <= mem[phys_b];
        end
    end

    assign bus.rd_data_a  = rd_data_a_q;
    assign bus.rd_data_b  = rd_data_b_q;
    assign bus.rd_valid_a = rd_valid_a_q;
    assign bus.rd_valid_b = rd_valid_b_q;
    assign bus.busy       = (state_q == CAPTURE);
    assign bus.done       = (state_q == DONE);
    assign bus.count      = count_q;
endmodule

// File: tb/tb_adc_capture_buf.sv
module tb_adc_capture_buf;
    localparam int ND    = 14;
    localparam int NA    = 8;
    localparam int DEPTH = 1 << NA;
    localparam int S_IDLE = 0, S_CAP = 1, S_DONE = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_capture_buf_if #(.ND(ND), .NA(NA)) bus ();
    adc_capture_buf #(.ND(ND), .NA(NA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Logical view: the captured samples as a queue (oldest first, at most DEPTH).
    // Physical view: the k-th sample of a capture lands in slot k mod DEPTH and
    // survives until overwritten (used for reads before DONE and stale reads).
    int            m_state = S_IDLE;
    bit            m_mode  = 0;
    int            wtot    = 0;
    logic [ND-1:0] q[$];
    logic [ND-1:0] m_phys  [DEPTH];
    bit            m_known [DEPTH];
    bit            ev_a = 0, ev_b = 0, ek_a = 1, ek_b = 1;
    logic [ND-1:0] ed_a = '0, ed_b = '0;

    function automatic logic [ND:0] lookup(input logic [NA-1:0] a);
        if (m_state == S_DONE && q.size() == DEPTH) return {1'b1, q[a]};
        return {m_known[a], m_phys[a]};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_state = S_IDLE;
            q.delete();
            ev_a = 0; ev_b = 0; ed_a = '0; ed_b = '0; ek_a = 1; ek_b = 1;
        end else begin
            ev_a = bus.rd_en_a;
            ev_b = bus.rd_en_b;
            if (bus.rd_en_a) {ek_a, ed_a} = lookup(bus.rd_addr_a);
            if (bus.rd_en_b) {ek_b, ed_b} = lookup(bus.rd_addr_b);
            if (bus.start) begin
                m_state = S_CAP; m_mode = bus.mode; q.delete(); wtot = 0;
            end else if (m_state == S_CAP) begin
                if (bus.sample_valid) begin
                    q.push_back(bus.data_i);
                    if (q.size() > DEPTH) void'(q.pop_front());
                    m_phys[wtot % DEPTH]  = bus.data_i;
                    m_known[wtot % DEPTH] = 1;
                    wtot++;
                end
                if ((!m_mode && q.size() == DEPTH) || (m_mode && bus.stop)) m_state = S_DONE;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy",  32'(bus.busy),  32'(m_state == S_CAP));
            chk("done",  32'(bus.done),  32'(m_state == S_DONE));
            chk("count", 32'(bus.count), 32'(q.size()));
            chk("rd_valid_a", 32'(bus.rd_valid_a), 32'(ev_a));
            chk("rd_valid_b", 32'(bus.rd_valid_b), 32'(ev_b));
            if (ek_a) chk("rd_data_a", 32'(bus.rd_data_a), 32'(ed_a));
            if (ek_b) chk("rd_data_b", 32'(bus.rd_data_b), 32'(ed_b));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit m);
        bus.start = 1; bus.mode = m;
        tick();
        bus.start = 0;
    endtask

    task automatic push(input int d);
        bus.sample_valid = 1; bus.data_i = ND'(d);
        tick();
        bus.sample_valid = 0;
    endtask

    task automatic do_stop();
        bus.stop = 1;
        tick();
        bus.stop = 0;
    endtask

    task automatic rd(input int a, input int b);
        bus.rd_en_a = 1; bus.rd_addr_a = NA'(a);
        bus.rd_en_b = 1; bus.rd_addr_b = NA'(b);
        tick();
        bus.rd_en_a = 0; bus.rd_en_b = 0;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.sample_valid = 0; bus.data_i = '0;
        bus.rd_en_a = 0; bus.rd_en_b = 0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        for (int i = 0; i < DEPTH; i++) begin m_known[i] = 0; m_phys[i] = '0; end
        repeat (2) tick();
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_valid_a", 32'(bus.rd_valid_a), 0);
        chk("rst_data_b",  32'(bus.rd_data_b), 0);
        rst_n = 1; chk_en = 1;
        tick();

        // single-shot 0..255
        pulse_start(0);
        for (int i = 0; i < DEPTH; i++) begin
            push(i);
            if (i == DEPTH - 2) chk("ss_not_done_early", 32'(bus.done), 0);
        end
        chk("ss_done", 32'(bus.done), 1);
        chk("ss_count", 32'(bus.count), 256);
        rd(0, 255);
        chk("ss_rd0", 32'(bus.rd_data_a), 0);
        chk("ss_rd255", 32'(bus.rd_data_b), 255);
        tick();
        chk("ss_hold_valid", 32'(bus.rd_valid_b), 0);
        chk("ss_hold_data", 32'(bus.rd_data_b), 255);

        // continuous 0..299, read/write collision at sample 260 (slot 4)
        pulse_start(1);
        for (int i = 0; i < 300; i++) begin
            if (i == 260) begin bus.rd_en_a = 1; bus.rd_addr_a = 8'd4; end
            push(i);
            bus.rd_en_a = 0;
            if (i == 260) chk("collision_old", 32'(bus.rd_data_a), 4);
        end
        chk("ring_busy_before_stop", 32'(bus.busy), 1);
        do_stop();
        chk("ring_done", 32'(bus.done), 1);
        chk("ring_count", 32'(bus.count), 256);
        rd(0, 255);
        chk("ring_oldest", 32'(bus.rd_data_a), 44);
        chk("ring_newest", 32'(bus.rd_data_b), 299);

        // partial continuous capture of 10 samples
        pulse_start(1);
        for (int i = 0; i < 10; i++) push(1000 + i);
        do_stop();
        chk("part_count", 32'(bus.count), 10);
        rd(9, 0);
        chk("part_rd9", 32'(bus.rd_data_a), 1009);
        chk("part_rd0", 32'(bus.rd_data_b), 1000);
        rd(20, 9);
        chk("stale_rd20", 32'(bus.rd_data_a), 276);
        chk("stale_valid", 32'(bus.rd_valid_a), 1);

        // dual reads
        rd(5, 200);
        chk("dual_a5", 32'(bus.rd_data_a), 1005);
        chk("dual_b200", 32'(bus.rd_data_b), 200);
        rd(200, 5);
        chk("dual_a200", 32'(bus.rd_data_a), 200);
        chk("dual_b5", 32'(bus.rd_data_b), 1005);
        rd(7, 7);
        chk("same_a", 32'(bus.rd_data_a), 1007);
        chk("same_b", 32'(bus.rd_data_b), 1007);
        tick();
        chk("hold_valid_a", 32'(bus.rd_valid_a), 0);
        chk("hold_data_a", 32'(bus.rd_data_a), 1007);

        // start+stop together restarts; stop with sample_valid stores it
        pulse_start(1);
        for (int i = 0; i < 5; i++) push(2000 + i);
        bus.start = 1; bus.stop = 1; bus.mode = 1;
        tick();
        bus.start = 0; bus.stop = 0;
        chk("ss_collide_busy", 32'(bus.busy), 1);
        chk("ss_collide_count", 32'(bus.count), 0);
        for (int i = 0; i < 3; i++) push(2100 + i);
        bus.stop = 1; bus.sample_valid = 1; bus.data_i = ND'(2103);
        tick();
        bus.stop = 0; bus.sample_valid = 0;
        chk("stopwr_done", 32'(bus.done), 1);
        chk("stopwr_count", 32'(bus.count), 4);
        rd(3, 0);
        chk("stopwr_last", 32'(bus.rd_data_a), 2103);
        chk("stopwr_first", 32'(bus.rd_data_b), 2100);

        // stop ignored in single-shot
        pulse_start(0);
        for (int i = 0; i < 3; i++) push(2200 + i);
        do_stop();
        chk("ss_stop_ignored_busy", 32'(bus.busy), 1);
        chk("ss_stop_ignored_count", 32'(bus.count), 3);

        // asynchronous reset at sample 100
        pulse_start(0);
        for (int i = 0; i < 100; i++) begin
            if (i == 99) begin bus.rd_en_a = 1; bus.rd_addr_a = '0; end
            push(3000 + i);
            bus.rd_en_a = 0;
        end
        chk("pre_rst_count", 32'(bus.count), 100);
        chk("pre_rst_rd", 32'(bus.rd_data_a), 3000);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_valid_a", 32'(bus.rd_valid_a), 0);
        chk("arst_data_a", 32'(bus.rd_data_a), 0);
        chk("arst_data_b", 32'(bus.rd_data_b), 0);
        bus.sample_valid = 1; bus.data_i = '1;
        tick();
        rst_n = 1;
        repeat (3) tick();
        bus.sample_valid = 0;
        chk("post_rst_idle", 32'(bus.busy), 0);
        rd(0, 150);
        chk("post_rst_rd0", 32'(bus.rd_data_a), 3000);
        chk("post_rst_rd150", 32'(bus.rd_data_b), 150);
        rd(99, 100);
        chk("post_rst_rd99", 32'(bus.rd_data_a), 3099);
        chk("post_rst_rd100", 32'(bus.rd_data_b), 100);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_capture_buf.md
ADC_CAPTURE_BUF -- requirements
Module: adc_capture_buf

Interface
REQ-001 SHALL have parameter ND, default 14: sample width in bits.
REQ-002 SHALL have parameter NA, default 8: address width; DEPTH = 2^NA (256 by default).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic; all activity on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a capture.
REQ-006 SHALL have port stop, input, 1 bit: one-cycle pulse that ends a continuous capture.
REQ-007 SHALL have port mode, input, 1 bit: 0 = single-shot, 1 = continuous ring; sampled only when start is accepted.
REQ-008 SHALL have port sample_valid, input, 1 bit: data_i is valid this cycle.
REQ-009 SHALL have port data_i, input, ND bits: ADC sample.
REQ-010 SHALL have ports rd_en_a and rd_en_b, input, 1 bit each: read enables for port A (serial) and port B (FFT).
REQ-011 SHALL have ports rd_addr_a and rd_addr_b, input, NA bits each: logical read addresses, 0 = oldest sample.
REQ-012 SHALL have ports rd_data_a and rd_data_b, output, ND bits each: read data.
REQ-013 SHALL have ports rd_valid_a and rd_valid_b, output, 1 bit each: read data valid.
REQ-014 SHALL have port busy, output, 1 bit: high in CAPTURE.
REQ-015 SHALL have port done, output, 1 bit: high in DONE.
REQ-016 SHALL have port count, output, NA+1 bits: number of samples held, saturating at DEPTH.

Function
REQ-017 SHALL implement states IDLE, CAPTURE and DONE.
REQ-018 SHALL go from IDLE or DONE to CAPTURE on start, clearing wr_ptr and count and latching mode.
REQ-019 SHALL, on start during CAPTURE, restart the capture exactly as in REQ-018.
REQ-020 SHALL give start priority when start and stop are asserted in the same cycle.
REQ-021 SHALL, in CAPTURE with sample_valid high, write data_i to physical address wr_ptr, increment wr_ptr modulo DEPTH, and increment count saturating at DEPTH.
REQ-022 SHALL, in single-shot mode, enter DONE on the cycle after the DEPTH-th write; stop is ignored in this mode.
REQ-023 SHALL, in continuous mode, keep writing with wrap-around, overwriting the oldest samples, until stop.
REQ-024 SHALL, when stop arrives in continuous mode together with sample_valid, write that sample and then enter DONE.
REQ-025 SHALL ignore sample_valid in IDLE and DONE; memory is not modified in those states.
REQ-026 SHALL latch base on entry to DONE: base = wr_ptr if count == DEPTH, else 0.
REQ-027 SHALL map each read port to physical address (base + rd_addr) mod DEPTH; base is 0 outside DONE.
REQ-028 SHALL give each read port a latency of 1: rd_en high at edge N yields rd_data and rd_valid = 1 after edge N.
REQ-029 SHALL, with rd_en low, hold rd_data at its last value and drive rd_valid = 0.
REQ-030 SHALL operate ports A and B independently and simultaneously, including reads of the same address.
REQ-031 SHALL, on a read and a write to the same physical address in the same cycle, return the old (pre-write) data.
REQ-032 SHALL not range-check reads: reads of addresses >= count return stale memory contents, still with rd_valid = 1.
REQ-033 SHALL hold the state in DONE until start.

Reset
REQ-034 SHALL, while rst_n is low, immediately force state = IDLE, wr_ptr = 0, count = 0, base = 0, busy = 0, done = 0, rd_data_a/b = 0 and rd_valid_a/b = 0.
REQ-035 SHALL abandon any capture in progress on reset mid-capture; a new start is required after release.
REQ-036 SHALL leave memory contents unaffected by reset; the memory maps to block RAM.

Verification
REQ-037 Single-shot: mode = 0, start, 256 samples with values 0..255 -> done = 1 one cycle after the last write, count = 256, rd_addr_a = 0 -> 0, rd_addr_a = 255 -> 255.
REQ-038 Continuous wrap: mode = 1, 300 samples with values 0..299, then stop -> count = 256, base = 44, logical address 0 reads 44 and logical address 255 reads 299.
REQ-039 Partial continuous capture: mode = 1, 10 samples then stop -> count = 10, base = 0, logical address 9 reads the 10th sample.
REQ-040 Dual read: both ports read addresses 5 and 200 in the same cycle -> both data correct after 1 cycle; rd_en low holds data with rd_valid = 0.
REQ-041 Collisions: start+stop in the same cycle -> stays in CAPTURE with counters cleared; stop together with sample_valid -> that sample is stored and DONE is entered.
REQ-042 Reset: rst_n low at sample 100 of a capture -> IDLE with all outputs 0 without waiting for a clock edge; no writes until the next start.
